// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: coefficient width, modulus and coefficient type.
package ntt_pkg;

    localparam int COEF_WIDTH = 28;

    // Q = 2^28 - 2^16 + 1
    localparam logic [COEF_WIDTH-1:0] Q = 28'hFFF_0001;

    typedef logic [COEF_WIDTH-1:0] coef_t;

endpackage

// File: rtl/ntt_pair_former_if.sv
// Bundles the pair former's coefficient input stream and butterfly-pair output stream.
interface ntt_pair_former_if
    import ntt_pkg::*;
#(
    parameter int WIDTH = COEF_WIDTH,
    parameter int LOG_D = 4
);
    logic             in_valid;
    logic             in_sync;
    logic [WIDTH-1:0] in_data;

    logic             out_valid;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic [LOG_D-1:0] out_idx;

    modport master (
        output in_valid, in_sync, in_data,
        input  out_valid, out_x, out_y, out_idx
    );

    modport slave (
        input  in_valid, in_sync, in_data,
        output out_valid, out_x, out_y, out_idx
    );
endinterface

// File: rtl/ntt_delay_ram.sv
// WIDTH x 2^ADDR_W delay buffer: one synchronous write port, asynchronous read, no reset.
module ntt_delay_ram #(
    parameter int WIDTH  = 28,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/ntt_pair_former.sv
// Reorders a natural-order coefficient stream into butterfly pairs (a[k], a[k+D]):
// the first half of each 2D block is buffered, the second half is paired against it.
module ntt_pair_former
    import ntt_pkg::*;
#(
    parameter int WIDTH = COEF_WIDTH,
    parameter int LOG_D = 4
) (
    input  logic           clk,
    input  logic           rst,
    ntt_pair_former_if.slave bus
);
    localparam logic [LOG_D:0] CNT_ONE = {{LOG_D{1'b0}}, 1'b1};

    // cnt[LOG_D] is the phase (0 fill, 1 pair); the low bits are the slot
    logic [LOG_D:0]   cnt;
    logic [LOG_D:0]   cnt_cur;
    logic [LOG_D-1:0] slot;
    logic             is_pair;
    logic             wr_en;
    logic [WIDTH-1:0] partner;

    always_comb begin
        // a synced sample restarts the block as fill slot 0; only used when in_valid is set
        cnt_cur = bus.in_sync ? '0 : cnt;
        slot    = cnt_cur[LOG_D-1:0];
        is_pair = bus.in_valid & cnt_cur[LOG_D];
        wr_en   = bus.in_valid & ~cnt_cur[LOG_D] & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.in_valid) begin
            cnt <= cnt_cur + CNT_ONE;
        end
    end

    // Next block's fill write to a slot lands after this block's pair read of it, so one
    // shared address is hazard-free.
    ntt_delay_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (LOG_D)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (slot),
        .wr_data (bus.in_data),
        .rd_addr (slot),
        .rd_data (partner)
    );

    always_ff @(posedge clk) begin
        if (rst || !is_pair) begin
            bus.out_valid <= 1'b0;
            bus.out_x     <= '0;
            bus.out_y     <= '0;
            bus.out_idx   <= '0;
        end else begin
            bus.out_valid <= 1'b1;
            bus.out_x     <= partner;
            bus.out_y     <= bus.in_data;
            bus.out_idx   <= slot;
        end
    end
endmodule

// File: tb/tb_ntt_pair_former.sv
// Directed bench for ntt_pair_former with D=4: stimulus pushes hand-computed pairs, a monitor checks them.
module tb_ntt_pair_former;
    localparam int W  = 28;
    localparam int LD = 2;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [LD-1:0] idx;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    ntt_pair_former_if #(.WIDTH(W), .LOG_D(LD)) bus ();

    ntt_pair_former #(.WIDTH(W), .LOG_D(LD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        rst          = r;
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic fill(input logic s, input logic [W-1:0] d);
        step(1'b0, 1'b1, s, d);
    endtask

    // second-half sample; expected pair appears one cycle after it is accepted
    task automatic pair(input logic [W-1:0] d, input logic [W-1:0] x, input logic [LD-1:0] k);
        exp_t e;
        step(1'b0, 1'b1, 1'b0, d);
        e.x = x; e.y = d; e.idx = k; e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                total++; bad++;
                $display("FAIL missing_pair cyc=%0d expected x=%0h y=%0h idx=%0d due at cyc %0d",
                         cyc, exp_q[0].x, exp_q[0].y, exp_q[0].idx, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            total++;
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pair cyc=%0d got x=%0h y=%0h idx=%0d required no output",
                             cyc, bus.out_x, bus.out_y, bus.out_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || bus.out_x !== e.x || bus.out_y !== e.y || bus.out_idx !== e.idx) begin
                        bad++;
                        $display("FAIL pair cyc=%0d got x=%0h y=%0h idx=%0d required x=%0h y=%0h idx=%0d at cyc %0d",
                                 cyc, bus.out_x, bus.out_y, bus.out_idx, e.x, e.y, e.idx, e.cyc);
                    end
                end
            end else if (bus.out_valid !== 1'b0 || bus.out_x !== '0 || bus.out_y !== '0 || bus.out_idx !== '0) begin
                bad++;
                $display("FAIL idle_out cyc=%0d got v=%b x=%0h y=%0h idx=%0d required all zero",
                         cyc, bus.out_valid, bus.out_x, bus.out_y, bus.out_idx);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = '0;
        do_reset();
        mon_en = 1'b1;

        // plain block 0..7
        fill(1'b1, 0);
        for (int i = 1; i < 4; i++) fill(1'b0, i);
        pair(4, 0, 0); pair(5, 1, 1); pair(6, 2, 2); pair(7, 3, 3);
        idle(); idle();

        // gaps after samples 1 and 5
        do_reset();
        fill(1'b1, 0); fill(1'b0, 1); idle(); fill(1'b0, 2); fill(1'b0, 3);
        pair(4, 0, 0); pair(5, 1, 1); idle(); pair(6, 2, 2); pair(7, 3, 3);
        idle(); idle();

        // two back-to-back blocks 0..15
        do_reset();
        fill(1'b1, 0);
        for (int i = 1; i < 4; i++) fill(1'b0, i);
        pair(4, 0, 0); pair(5, 1, 1); pair(6, 2, 2); pair(7, 3, 3);
        for (int i = 8; i < 12; i++) fill(1'b0, i);
        pair(12, 8, 0); pair(13, 9, 1); pair(14, 10, 2); pair(15, 11, 3);
        idle(); idle();

        // resync at sample 6 of stream 0..13
        do_reset();
        fill(1'b1, 0);
        for (int i = 1; i < 4; i++) fill(1'b0, i);
        pair(4, 0, 0); pair(5, 1, 1);
        fill(1'b1, 6); fill(1'b0, 7); fill(1'b0, 8); fill(1'b0, 9);
        pair(10, 6, 0); pair(11, 7, 1); pair(12, 8, 2); pair(13, 9, 3);
        idle(); idle();

        // reset arriving with sample 5, then 100..107 without sync
        do_reset();
        fill(1'b1, 0);
        for (int i = 1; i < 4; i++) fill(1'b0, i);
        pair(4, 0, 0);
        step(1'b1, 1'b1, 1'b0, 5);
        for (int i = 100; i < 104; i++) fill(1'b0, i);
        pair(104, 100, 0); pair(105, 101, 1); pair(106, 102, 2); pair(107, 103, 3);
        idle(); idle();

        // full-scale and minimal operands pass bit-exact
        do_reset();
        fill(1'b1, 28'hFFFFFFF);
        for (int i = 1; i < 4; i++) fill(1'b0, 28'hFFFFFFF);
        pair(28'h0000001, 28'hFFFFFFF, 0); pair(28'h0000001, 28'hFFFFFFF, 1);
        pair(28'h0000001, 28'hFFFFFFF, 2); pair(28'h0000001, 28'hFFFFFFF, 3);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle();
        idle(); idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pairs outstanding required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ntt_pair_former.md
Name: ntt_pair_former

Overview:
- Stream-to-pair reorder stage directly upstream of the NTT butterfly.
- Accepts one 28-bit coefficient per cycle in natural order and emits butterfly operand pairs (x = a[k], y = a[k+D]) for each block of 2D consecutive samples.
- Single-path delay-feedback style: the first D samples of a block are buffered, then each second-half sample is paired with its buffered partner.
- Output is a registered, fully pipelined stream with no backpressure, matching the butterfly's fixed-latency pipeline.

Parameters:
- WIDTH, 28, coefficient width in bits.
- LOG_D, 4, log2 of pair distance; D = 2^LOG_D, block length 2D.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is a valid sample this cycle.
- in_sync  input  1  qualified by in_valid; marks this sample as index 0 of a new block.
- in_data  input  WIDTH  coefficient sample.
- out_valid  output  1  out_x/out_y/out_idx hold a valid pair.
- out_x  output  WIDTH  first-half operand a[k], to butterfly x_in.
- out_y  output  WIDTH  second-half operand a[k+D], to butterfly y_in.
- out_idx  output  LOG_D  pair index k within block; used for twiddle selection.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: out_valid=0, out_x=0, out_y=0, out_idx=0, sample counter cnt=0.
- Buffer contents are not reset and are don't-care until written.
- State:
  - Counter cnt is LOG_D+1 bits. cnt[LOG_D] is the phase: 0 = FILL, 1 = PAIR. cnt[LOG_D-1:0] is the slot.
  - cnt advances by 1 only on an accepted sample (in_valid=1). It wraps from 2D-1 to 0.
- in_sync rule: if in_valid and in_sync are both 1, the sample is treated as cnt=0 (FILL, slot 0) regardless of the current count, and cnt becomes 1 next cycle.
  - Any partially formed block is abandoned and no pairs are emitted for it.
  - in_sync with in_valid=0 is ignored.
- FILL sample: write in_data to buf[slot]. No output is produced.
- PAIR sample:
  - Read buf[slot] combinationally (distributed memory).
  - Register out_x=buf[slot], out_y=in_data, out_idx=slot, out_valid=1 on the next edge.
- Latency: exactly 1 cycle from a PAIR sample's in_valid edge to its out_valid.
- Throughput: 1 pair per cycle during PAIR phase. Average 1 pair per 2 input samples.
- Output when idle: on any cycle without a PAIR sample, out_valid=0 and out_x/out_y/out_idx are driven to 0 next edge.
- Gaps: in_valid=0 cycles anywhere in a block stall cnt and the buffer. The output gets a matching bubble. Pairing is unaffected.
- Back-to-back blocks: the FILL write of block n+1 slot s occurs after the PAIR read of block n slot s. No read/write hazard; no dead cycle between blocks.
- Reset mid-block: a pair in flight is dropped (outputs 0 next cycle). cnt returns to 0, and the next valid sample is FILL slot 0.
- rst has priority over in_valid/in_sync in the same cycle.
- Data is passed bit-exact. No modular reduction is performed; inputs are already < q.

Decomposition:
- Shared package ntt_pkg holds:
  - COEF_WIDTH=28 and modulus constant Q = 2^28 - 2^16 + 1.
  - typedef coef_t = logic [COEF_WIDTH-1:0].
- One sub-module: ntt_delay_ram (WIDTH x D).
  - Single write port, asynchronous read, no reset.
  - Reusable by the downstream output reorder stage.
- Counter, phase decode and output register live in ntt_pair_former.

Test Plan (LOG_D=2, D=4):
- rst, then continuous in_valid with in_sync on the first sample, data 0..7 -> out_valid on 4 consecutive cycles starting 1 cycle after sample 4. Pairs (0,4),(1,5),(2,6),(3,7), out_idx 0..3. out_valid=0 during the fill cycles.
- Same stream with in_valid=0 inserted after samples 1 and 5 -> identical pairs and out_idx. A single bubble appears in the output between pairs (1,5) and (2,6).
- Two back-to-back blocks, data 0..15 -> 8 pairs: (0,4)..(3,7), then 4 idle cycles, then (8,12)..(11,15). No corruption of block-2 pairs.
- in_sync asserted at sample 6 of a stream 0..13 -> no pairs for samples 4,5 beyond (0,4),(1,5). Samples 6..13 form a new block giving (6,10),(7,11),(8,12),(9,13).
- rst asserted on the cycle sample 5 arrives -> no pair for sample 5. The next 8 samples 100..107 give (100,104)..(103,107).
- Data 0xFFFFFFF in first half, 0x0000001 in second half -> out_x=0xFFFFFFF, out_y=0x0000001 exactly. A connected butterfly then receives the correct operands.
